// File: rtl/encode_mul_pkg.sv
// encode_mul_pkg: shared widths and wide-math helpers for the encoder multiply-accumulate pipe.
package encode_mul_pkg;

    // Helpers work on a wide signed container so they serve any parameter set.
    localparam int MAXW = 256;
    localparam logic signed [MAXW-1:0] ONE = 1;

    function automatic int acc_width(input int w0, input int w1, input int guard);
        return w0 + w1 + guard;
    endfunction

    function automatic logic signed [MAXW-1:0] round_shift(input logic signed [MAXW-1:0] v, input int s);
        return (s == 0) ? v : (v + (ONE <<< (s - 1))) >>> s;
    endfunction

    function automatic logic signed [MAXW-1:0] sat_clamp(input logic signed [MAXW-1:0] v, input int w);
        logic signed [MAXW-1:0] hi, lo;
        hi = (ONE <<< (w - 1)) - ONE;
        lo = -(ONE <<< (w - 1));
        return (v > hi) ? hi : (v < lo) ? lo : v;
    endfunction

endpackage

// File: rtl/encode_mul_sat_round.sv
// encode_mul_sat_round: round-half-up right shift followed by saturation to the output width.
module encode_mul_sat_round
    import encode_mul_pkg::*;
#(
    parameter int ACC_WIDTH  = 66,
    parameter int DOUT_WIDTH = 61,
    parameter int FRAC_SHIFT = 0
) (
    input  logic signed [ACC_WIDTH-1:0]  acc_next_i,
    output logic signed [DOUT_WIDTH-1:0] dout_o,
    output logic                         sat_o
);

    logic signed [MAXW-1:0] wide, r, c;

    always_comb begin
        wide = MAXW'(acc_next_i);
        r    = round_shift(wide, FRAC_SHIFT);
        c    = sat_clamp(r, DOUT_WIDTH);
    end

    assign dout_o = c[DOUT_WIDTH-1:0];
    assign sat_o  = c != r;

endmodule

// File: rtl/encode_mul_acc_pipe.sv
// encode_mul_acc_pipe: pipelined signed multiplier with optional accumulate, rounding and saturation.
module encode_mul_acc_pipe
    import encode_mul_pkg::*;
#(
    parameter int DIN0_WIDTH = 40,
    parameter int DIN1_WIDTH = 22,
    parameter int DOUT_WIDTH = 61,
    parameter int NUM_STAGE  = 2,
    parameter int ACC_GUARD  = 4,
    parameter int FRAC_SHIFT = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ce,
    input  logic                         in_valid,
    input  logic signed [DIN0_WIDTH-1:0] din0,
    input  logic signed [DIN1_WIDTH-1:0] din1,
    input  logic                         acc_en,
    input  logic                         acc_clr,
    output logic signed [DOUT_WIDTH-1:0] dout,
    output logic                         out_valid,
    output logic                         sat
);

    localparam int P         = DIN0_WIDTH + DIN1_WIDTH;
    localparam int ACC_WIDTH = acc_width(DIN0_WIDTH, DIN1_WIDTH, ACC_GUARD);
    localparam int L         = NUM_STAGE - 1;

    if (NUM_STAGE < 1) begin : g_bad_stage
        $error("NUM_STAGE must be at least 1");
    end
    if (FRAC_SHIFT < 0 || FRAC_SHIFT >= ACC_WIDTH) begin : g_bad_shift
        $error("FRAC_SHIFT must lie in [0, ACC_WIDTH)");
    end
    if (ACC_WIDTH + 1 >= MAXW || DOUT_WIDTH >= MAXW) begin : g_bad_width
        $error("widths exceed the helper container");
    end

    logic signed [P-1:0]          prod_q [NUM_STAGE];
    logic [NUM_STAGE-1:0]         vld_q, en_q, clr_q;
    logic signed [ACC_WIDTH-1:0]  prod_x, acc_q, acc_next_d;
    logic signed [DOUT_WIDTH-1:0] dout_d, dout_q;
    logic                         sat_d, sat_q, out_valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q[0] <= 1'b0;
        end else if (ce) begin
            vld_q[0]  <= in_valid;
            prod_q[0] <= din0 * din1;
            en_q[0]   <= acc_en;
            clr_q[0]  <= acc_clr;
        end
    end

    for (genvar s = 1; s < NUM_STAGE; s++) begin : g_dly
        always_ff @(posedge clk) begin
            if (reset) begin
                vld_q[s] <= 1'b0;
            end else if (ce) begin
                vld_q[s]  <= vld_q[s-1];
                prod_q[s] <= prod_q[s-1];
                en_q[s]   <= en_q[s-1];
                clr_q[s]  <= clr_q[s-1];
            end
        end
    end

    assign prod_x     = ACC_WIDTH'(prod_q[L]);
    assign acc_next_d = (en_q[L] && !clr_q[L]) ? acc_q + prod_x : prod_x;

    encode_mul_sat_round #(
        .ACC_WIDTH (ACC_WIDTH),
        .DOUT_WIDTH(DOUT_WIDTH),
        .FRAC_SHIFT(FRAC_SHIFT)
    ) u_sat_round (
        .acc_next_i(acc_next_d),
        .dout_o    (dout_d),
        .sat_o     (sat_d)
    );

    // Pass-through samples still produce a result but leave the running sum untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q       <= '0;
            dout_q      <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (ce) begin
            out_valid_q <= vld_q[L];
            if (vld_q[L]) begin
                dout_q <= dout_d;
                sat_q  <= sat_d;
                if (en_q[L]) acc_q <= acc_next_d;
            end
        end
    end

    assign dout      = dout_q;
    assign sat       = sat_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_encode_mul_acc_pipe.sv
// tb_encode_mul_acc_pipe: directed and random checks of the multiply-accumulate pipe against a queue model.
module tb_encode_mul_acc_pipe;

    localparam int NS = 2;
    localparam logic signed [39:0] MIN0 = {1'b1, 39'b0};
    localparam logic signed [39:0] MAX0 = {1'b0, {39{1'b1}}};
    localparam logic signed [21:0] MIN1 = {1'b1, 21'b0};

    logic clk = 1'b0;
    logic rst, ce, iv, ae, ac;
    logic signed [39:0] a;
    logic signed [21:0] b;
    logic signed [60:0] dout;
    logic out_valid, sat;

    logic b_iv = 1'b0;
    logic signed [39:0] b_d0 = '0;
    logic signed [21:0] b_d1 = '0;
    logic signed [60:0] b_dout;
    logic b_ov, b_sat;

    always #5 clk = ~clk;

    encode_mul_acc_pipe u_dut (
        .clk(clk), .reset(rst), .ce(ce), .in_valid(iv), .din0(a), .din1(b),
        .acc_en(ae), .acc_clr(ac), .dout(dout), .out_valid(out_valid), .sat(sat)
    );

    encode_mul_acc_pipe #(.NUM_STAGE(3), .FRAC_SHIFT(4)) u_b (
        .clk(clk), .reset(rst), .ce(1'b1), .in_valid(b_iv), .din0(b_d0), .din1(b_d1),
        .acc_en(1'b0), .acc_clr(1'b0), .dout(b_dout), .out_valid(b_ov), .sat(b_sat)
    );

    typedef struct {
        int                 due;
        logic signed [127:0] d;
        logic               s;
    } res_t;

    res_t q[$];
    int edges = 0;
    int vectors = 0;
    int errors = 0;
    logic signed [127:0] acc_m = '0, last_d = '0;
    logic last_s = 1'b0;

    function automatic logic signed [127:0] wrap66(input logic signed [127:0] x);
        logic signed [65:0] t;
        t = x[65:0];
        return t;
    endfunction

    function automatic logic signed [127:0] clamp61(input logic signed [127:0] x);
        logic signed [127:0] hi, lo;
        hi = (128'sd1 <<< 60) - 128'sd1;
        lo = -(128'sd1 <<< 60);
        return (x > hi) ? hi : (x < lo) ? lo : x;
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic c, input logic v, input logic signed [39:0] x,
                        input logic signed [21:0] y, input logic e, input logic cl);
        logic signed [127:0] p, pb, an, cv;
        logic exp_ov;
        rst = r; ce = c; iv = v; a = x; b = y; ae = e; ac = cl;
        @(posedge clk);
        #1;
        if (r) begin
            q.delete();
            acc_m  = '0;
            last_d = '0;
            last_s = 1'b0;
        end else if (c) begin
            edges++;
            if (v) begin
                p  = x;
                pb = y;
                p  = p * pb;
                an = (e && !cl) ? wrap66(acc_m + p) : p;
                if (e) acc_m = an;
                cv = clamp61(an);
                q.push_back('{edges + NS, cv, cv != an});
            end
        end
        while (q.size() > 0 && q[0].due < edges) void'(q.pop_front());
        exp_ov = !r && q.size() > 0 && q[0].due == edges;
        if (exp_ov) begin
            last_d = q[0].d;
            last_s = q[0].s;
        end
        chk("out_valid", out_valid, exp_ov);
        chk("dout", dout, last_d);
        chk("sat", sat, last_s);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        int bt[4];
        int bexp[4];
        logic [63:0] rr;
        logic signed [39:0] x;
        logic signed [21:0] y;
        int mode;
        bt   = '{9, 7, -9, -8};
        bexp = '{1, 0, -1, 0};

        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 40'sd3, -22'sd5, 0, 0);
        idle(4);
        step(0, 1, 1, MIN0, MIN1, 0, 0);
        step(0, 1, 1, MAX0, MIN1, 0, 0);
        idle(4);
        step(0, 1, 1, 40'sd10, 22'sd10, 1, 1);
        step(0, 1, 1, 40'sd2, 22'sd3, 1, 0);
        step(0, 1, 1, 40'sd4, -22'sd1, 1, 0);
        step(0, 1, 1, 40'sd7, 22'sd1, 0, 0);
        step(0, 1, 1, 40'sd1, 22'sd1, 1, 0);
        idle(4);
        step(0, 1, 1, 40'sd1, 22'sd2, 0, 0);
        step(0, 1, 1, 40'sd3, 22'sd4, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 40'sd5, 22'sd6, 0, 0);
        step(0, 1, 1, 40'sd7, 22'sd8, 0, 0);
        step(0, 1, 1, 40'sd9, 22'sd1, 0, 0);
        idle(4);
        step(0, 1, 1, 40'sd10, 22'sd10, 1, 1);
        idle(4);
        step(0, 1, 1, 40'sd2, 22'sd2, 0, 0);
        step(0, 1, 1, 40'sd3, 22'sd3, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 40'sd1, 22'sd1, 1, 0);
        idle(4);

        for (int i = 0; i < 8; i++) begin
            b_iv = i < 4;
            b_d0 = 40'(bt[i % 4]);
            b_d1 = 22'sd1;
            idle(1);
            chk("b_out_valid", b_ov, i >= 3 && i <= 6);
            chk("b_sat", b_sat, 1'b0);
            if (i >= 3 && i <= 6) chk("b_dout", b_dout, 128'(bexp[i - 3]));
        end
        b_iv = 1'b0;

        for (int i = 0; i < 400; i++) begin
            mode = $urandom_range(0, 9);
            rr = {$urandom(), $urandom()};
            x = (mode < 2) ? (rr[0] ? MIN0 : MAX0) : (mode < 5) ? 40'($signed(rr[7:0])) : rr[39:0];
            y = (mode < 2) ? (rr[1] ? MIN1 : 22'sh1FFFFF) : (mode < 5) ? 22'($signed(rr[15:8])) : rr[61:40];
            step($urandom_range(0, 49) == 0, $urandom_range(0, 6) != 0, $urandom_range(0, 3) != 0,
                 x, y, $urandom_range(0, 2) != 0, $urandom_range(0, 4) == 0);
        end
        idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
